division_seq: RTL and testbench

- Sequential signed integer divider: the inverse of the datapath's single-cycle multiplier.
- The ALU launches it for the DIV operation and collects a quotient (LO) and a remainder (HI) through a start/done handshake.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Fixed latency, so the control unit sequences DIV with a counted wait.

---
 rtl/division_seq_pkg.sv | 16 +
 rtl/division_seq_if.sv | 25 ++
 rtl/division_seq.sv | 132 +++++++++++++
 tb/tb_division_seq.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/division_seq_pkg.sv
// Shared definitions for the sequential divider and the ALU/control logic that sequences DIV.
package division_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // DIV function code, shared by the ALU decoder and the control unit's counted wait
  localparam logic [5:0] ALU_OP_DIV = 6'b011010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/division_seq_if.sv
// Start/done handshake and operand/result bus between the ALU (master) and the divider (slave).
interface division_seq_if #(
  parameter int WIDTH = division_seq_pkg::DIV_WIDTH
);

  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/division_seq.sv
// Restoring radix-2 signed divider: one quotient bit per clock, fixed WIDTH+1 cycle latency.
module division_seq
  import division_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clock,
  input  logic          clear,
  division_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state;
  state_t state_next;

  // rem is always below the divisor magnitude, so WIDTH bits hold it; the step widens to WIDTH+1
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        dvs;
  logic signed [WIDTH-1:0] dvd_orig;
  logic                    sign_q;
  logic                    sign_r;
  logic                    zero_flag;
  logic [CNT_W-1:0]        count;

  logic [WIDTH-1:0]        quotient_r;
  logic [WIDTH-1:0]        remainder_r;
  logic                    done_r;
  logic                    dbz_r;

  logic [WIDTH:0]          shifted;
  logic [WIDTH:0]          trial;
  logic [WIDTH-1:0]        rem_step;
  logic [WIDTH-1:0]        quo_step;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (trial[WIDTH]) begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      dvd_orig    <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_flag   <= 1'b0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo       <= mag(bus.dividend);
            dvs       <= mag(bus.divisor);
            rem       <= '0;
            dvd_orig  <= bus.dividend;
            sign_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r    <= bus.dividend[WIDTH-1];
            zero_flag <= (bus.divisor == '0);
            count     <= CNT_W'(WIDTH - 1);
          end
        end
        CALC: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count - CNT_W'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          dbz_r  <= zero_flag;
          // A zero divisor reports all-ones and hands the original dividend back as remainder
          if (zero_flag) begin
            quotient_r  <= '1;
            remainder_r <= dvd_orig;
          end else begin
            quotient_r  <= apply_sign(sign_q, quo);
            remainder_r <= apply_sign(sign_r, rem);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_division_seq.sv
// Directed-vector bench for division_seq: signs, overflow, divide-by-zero, busy-start, clear abort.
module tb_division_seq;

  logic clock = 1'b0;
  logic clear = 1'b1;

  division_seq_if #(.WIDTH(32)) bus ();

  division_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int base, output int n);
    n = base;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 60);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int n;
    launch(a, b);
    chk({tag, " busy_rise"}, bus.busy, 1);
    wait_done(0, n);
    chk({tag, " latency"}, n, 33);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, bus.remainder, er);
    chk({tag, " div_by_zero"}, bus.div_by_zero, ez);
    chk({tag, " busy_fall"}, bus.busy, 0);
    tick();
    chk({tag, " done_width"}, bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    tick();
    tick();
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset div_by_zero", bus.div_by_zero, 0);
    clear = 1'b0;

    run("100/7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run("-100/7",  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    run("100/-7",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0);
    run("-100/-7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
    run("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    run("min/1",   32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0);
    run("5/0",     32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
    run("9/3",     32'd9,          32'd3,          32'd3,          32'd0,          1'b0);

    // Start during a run is ignored; held into the done cycle it launches immediately
    launch(32'd100, 32'd7);
    repeat (9) tick();
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    wait_done(9, n);
    chk("busy_start latency", n, 33);
    chk("busy_start quotient", bus.quotient, 14);
    chk("busy_start remainder", bus.remainder, 2);
    tick();
    bus.start = 1'b0;
    chk("b2b busy", bus.busy, 1);
    chk("b2b done_low", bus.done, 0);
    chk("b2b hold quotient", bus.quotient, 14);
    chk("b2b hold remainder", bus.remainder, 2);
    wait_done(0, n);
    chk("b2b latency", n, 33);
    chk("b2b quotient", bus.quotient, 10);
    chk("b2b remainder", bus.remainder, 0);

    run("-8/0",    32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1);

    // Asynchronous clear mid-run
    launch(32'd100, 32'd7);
    repeat (14) tick();
    #2 clear = 1'b1;
    #1;
    chk("clear busy", bus.busy, 0);
    chk("clear done", bus.done, 0);
    chk("clear quotient", bus.quotient, 0);
    chk("clear remainder", bus.remainder, 0);
    chk("clear div_by_zero", bus.div_by_zero, 0);
    #2 clear = 1'b0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("clear no_done", pulses, 0);
    chk("clear idle", bus.busy, 0);

    run("1000/10", 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
